// File: rtl/alu_wide_seq.sv
// Multi-word sequencer around a 16-bit combinational ALU: slices a wide operation
// least-significant first, chaining carry/borrow, and returns the assembled result.
module alu_wide_seq #(
  parameter int WORDS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [16*WORDS-1:0]  req_a,
  input  logic [16*WORDS-1:0]  req_b,
  input  logic [3:0]           req_select,
  input  logic                 req_mode,
  input  logic                 req_carry,
  output logic [15:0]          alu_a,
  output logic [15:0]          alu_b,
  output logic [3:0]           alu_select,
  output logic                 alu_mode,
  output logic                 alu_carry_in,
  input  logic [15:0]          alu_out,
  input  logic                 alu_carry_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [16*WORDS-1:0]  rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0]    idx;
  logic [16*WORDS-1:0] a_reg;
  logic [16*WORDS-1:0] b_reg;
  logic [16*WORDS-1:0] result_reg;
  logic [3:0]          select_reg;
  logic                mode_reg;
  logic                carry_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Carry only propagates between slices in arithmetic mode; logic-mode ALU carry is junk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      select_reg <= '0;
      mode_reg   <= 1'b0;
      carry_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_reg      <= req_a;
            b_reg      <= req_b;
            select_reg <= req_select;
            mode_reg   <= req_mode;
            carry_reg  <= req_carry & req_mode;
            idx        <= '0;
          end
        end
        RUN: begin
          result_reg[16*idx +: 16] <= alu_out;
          carry_reg                <= mode_reg & alu_carry_out;
          if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    alu_a        = '0;
    alu_b        = '0;
    alu_carry_in = 1'b0;
    if (state == RUN) begin
      alu_a        = a_reg[16*idx +: 16];
      alu_b        = b_reg[16*idx +: 16];
      alu_carry_in = carry_reg;
    end
  end

  assign alu_select = select_reg;
  assign alu_mode   = mode_reg;
  assign rsp_result = result_reg;
  assign rsp_carry  = carry_reg;
  assign rsp_zero   = ~|result_reg;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq: models the 16-bit ALU slice-wise and the
// whole wide operation with plain full-width arithmetic.
module tb_alu_wide_seq;

  localparam int WORDS = 2;
  localparam int W     = 16 * WORDS;
  localparam int WP    = W + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic [3:0]    req_select = '0;
  logic          req_mode = 1'b0;
  logic          req_carry = 1'b0;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [3:0]    alu_select;
  logic          alu_mode;
  logic          alu_carry_in;
  logic [15:0]   alu_out;
  logic          alu_carry_out;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_result;
  logic          rsp_carry;
  logic          rsp_zero;

  int errors = 0;
  int checks = 0;

  logic        cin_seen [8];
  logic [15:0] a_seen   [8];
  int          n_seen;
  int          lat;

  alu_wide_seq #(.WORDS(WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_select   (req_select),
    .req_mode     (req_mode),
    .req_carry    (req_carry),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_select   (alu_select),
    .alu_mode     (alu_mode),
    .alu_carry_in (alu_carry_in),
    .alu_out      (alu_out),
    .alu_carry_out(alu_carry_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero)
  );

  always #5 clk = ~clk;

  // External 16-bit ALU; logic ops drive carry_out high to expose any leak into the chain.
  logic [16:0] alu_t;
  always_comb begin
    alu_t = '0;
    case ({alu_mode, alu_select})
      5'b1_1001: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_carry_in);
      5'b1_0110: alu_t = {1'b0, alu_a} - {1'b0, alu_b} - 17'(alu_carry_in);
      5'b0_0110: alu_t = {1'b1, alu_a ^ alu_b};
      5'b0_1011: alu_t = {1'b1, alu_a & alu_b};
      5'b0_1110: alu_t = {1'b1, alu_a | alu_b};
      default:   alu_t = {1'b0, alu_a};
    endcase
  end
  assign alu_out       = alu_t[15:0];
  assign alu_carry_out = alu_t[16];

  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] sel, input logic mode, input logic cin,
                                 output logic [W-1:0] res, output logic carry);
    logic [W:0] t;
    t = '0;
    if (mode && sel == 4'b1001)       t = {1'b0, a} + {1'b0, b} + WP'(cin);
    else if (mode && sel == 4'b0110)  t = {1'b0, a} - {1'b0, b} - WP'(cin);
    else if (!mode && sel == 4'b0110) t = {1'b0, a ^ b};
    else if (!mode && sel == 4'b1011) t = {1'b0, a & b};
    else if (!mode && sel == 4'b1110) t = {1'b0, a | b};
    else                              t = {1'b0, a};
    res   = t[W-1:0];
    carry = t[W];
  endfunction

  // Carry into slice i is bit 16*i of the operation applied to the low i slices only.
  function automatic logic ref_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] sel, input logic mode, input logic cin,
                                   input int i);
    logic [W-1:0] m;
    logic [W-1:0] r;
    logic         c;
    if (!mode) return 1'b0;
    if (i == 0) return cin;
    m = (W'(1) << (16 * i)) - W'(1);
    ref_op(a & m, b & m, sel, mode, cin, r, c);
    return r[16*i];
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                       input logic mode, input logic cin);
    bit ok;
    ok         = 1'b0;
    req_a      = a;
    req_b      = b;
    req_select = sel;
    req_mode   = mode;
    req_carry  = cin;
    req_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: req_ready=%0b required 1", req_ready);
    end
  endtask

  task automatic collect();
    n_seen = 0;
    lat    = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      if (n_seen < 8) begin
        cin_seen[n_seen] = alu_carry_in;
        a_seen[n_seen]   = alu_a;
      end
      n_seen++;
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if (req_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL reset_req_ready[%0d]: got %0b required 1", pass, req_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_rsp_valid[%0d]: got %0b required 0", pass, rsp_valid);
      end
      checks++;
      if (rsp_result !== '0 || rsp_carry !== 1'b0 || rsp_zero !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_rsp[%0d]: got %h/%0b/%0b required 0/0/1", pass, rsp_result,
                 rsp_carry, rsp_zero);
      end
      checks++;
      if ({alu_a, alu_b, alu_select, alu_mode, alu_carry_in} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_alu[%0d]: got %h %h %h %0b %0b required all 0", pass, alu_a,
                 alu_b, alu_select, alu_mode, alu_carry_in);
      end
      if (pass == 0) begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va   [4] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h12345678, 32'h00010000};
    logic [W-1:0] vb   [4] = '{32'h00000001, 32'h00000001, 32'hFFFF0000, 32'h00000001};
    logic [3:0]   vs   [4] = '{4'b1001, 4'b1001, 4'b0110, 4'b0110};
    logic         vm   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic         vc   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] vr   [4] = '{32'h00010000, 32'h00000000, 32'hEDCB5678, 32'h0000FFFF};
    logic         vco  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         vz   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         vci0 [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic         vci1 [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 4; t++) begin
      issue(va[t], vb[t], vs[t], vm[t], vc[t]);
      collect();
      checks++;
      if (lat !== WORDS + 1) begin
        errors++; $display("[TB] FAIL dir%0d_latency: got %0d required %0d", t, lat, WORDS + 1);
      end
      checks++;
      if (rsp_result !== vr[t] || rsp_carry !== vco[t] || rsp_zero !== vz[t]) begin
        errors++;
        $display("[TB] FAIL dir%0d_rsp: got %h/%0b/%0b required %h/%0b/%0b", t, rsp_result,
                 rsp_carry, rsp_zero, vr[t], vco[t], vz[t]);
      end
      checks++;
      if (n_seen != 2 || cin_seen[0] !== vci0[t] || cin_seen[1] !== vci1[t]) begin
        errors++;
        $display("[TB] FAIL dir%0d_carry_in: got n=%0d %0b,%0b required n=2 %0b,%0b", t, n_seen,
                 cin_seen[0], cin_seen[1], vci0[t], vci1[t]);
      end
      handshake();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, er;
    logic [3:0]   sel;
    logic         mode, cin, ec;
    for (int t = 0; t < 25; t++) begin
      a    = W'({$urandom(), $urandom()});
      b    = W'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) b = ~a;
      if ($urandom_range(0, 3) == 0) b = a;
      mode = 1'($urandom_range(0, 1));
      cin  = 1'($urandom_range(0, 1));
      if (mode) sel = ($urandom_range(0, 1) == 0) ? 4'b1001 : 4'b0110;
      else begin
        case ($urandom_range(0, 2))
          0:       sel = 4'b0110;
          1:       sel = 4'b1011;
          default: sel = 4'b1110;
        endcase
      end
      ref_op(a, b, sel, mode, cin, er, ec);
      issue(a, b, sel, mode, cin);
      collect();
      checks++;
      if (rsp_result !== er || rsp_carry !== ec || rsp_zero !== (er == '0)) begin
        errors++;
        $display("[TB] FAIL rand%0d_rsp: got %h/%0b/%0b required %h/%0b/%0b (a=%h b=%h s=%b m=%0b c=%0b)",
                 t, rsp_result, rsp_carry, rsp_zero, er, ec, er == '0, a, b, sel, mode, cin);
      end
      checks++;
      if (n_seen != WORDS) begin
        errors++; $display("[TB] FAIL rand%0d_slices: got %0d required %0d", t, n_seen, WORDS);
      end else begin
        for (int i = 0; i < WORDS; i++) begin
          checks++;
          if (a_seen[i] !== a[16*i +: 16] || cin_seen[i] !== ref_cin(a, b, sel, mode, cin, i)) begin
            errors++;
            $display("[TB] FAIL rand%0d_slice%0d: got a=%h cin=%0b required a=%h cin=%0b", t, i,
                     a_seen[i], cin_seen[i], a[16*i +: 16], ref_cin(a, b, sel, mode, cin, i));
          end
        end
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1, b1, a2, b2, er1, er2;
    logic         ec1, ec2;
    a1 = W'({$urandom(), $urandom()});
    b1 = W'({$urandom(), $urandom()});
    a2 = W'({$urandom(), $urandom()});
    b2 = W'({$urandom(), $urandom()});
    ref_op(a1, b1, 4'b1001, 1'b1, 1'b1, er1, ec1);
    ref_op(a2, b2, 4'b0110, 1'b1, 1'b0, er2, ec2);
    issue(a1, b1, 4'b1001, 1'b1, 1'b1);
    collect();
    req_a = a2; req_b = b2; req_select = 4'b0110; req_mode = 1'b1; req_carry = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== er1 || rsp_carry !== ec1 ||
          rsp_zero !== (er1 == '0)) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got v=%0b rdy=%0b %h/%0b/%0b required v=1 rdy=0 %h/%0b/%0b",
                 i, rsp_valid, req_ready, rsp_result, rsp_carry, rsp_zero, er1, ec1, er1 == '0);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_after_handshake: got rdy=%0b v=%0b required rdy=1 v=0", req_ready,
               rsp_valid);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    collect();
    checks++;
    if (lat !== WORDS + 1 || rsp_result !== er2 || rsp_carry !== ec2) begin
      errors++;
      $display("[TB] FAIL bp_second: got lat=%0d %h/%0b required lat=%0d %h/%0b", lat, rsp_result,
               rsp_carry, WORDS + 1, er2, ec2);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_r[$];
    logic         exp_c[$];
    logic [W-1:0] er, gr;
    logic         ec, gc;
    bit           pending;
    int           acc, rsp, last_acc;
    pending   = 1'b1;
    acc       = 0;
    rsp       = 0;
    last_acc  = -1;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && rsp < 4; cyc++) begin
      if (pending && acc < 4) begin
        req_a = W'({$urandom(), $urandom()}); req_b = W'({$urandom(), $urandom()});
        req_select = 4'b1001; req_mode = 1'b1; req_carry = 1'($urandom_range(0, 1));
        req_valid = 1'b1; pending = 1'b0;
      end
      if (rsp_valid) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_extra_rsp: got %h required none", rsp_result);
        end else begin
          gr = exp_r.pop_front(); gc = exp_c.pop_front();
          if (rsp_result !== gr || rsp_carry !== gc) begin
            errors++;
            $display("[TB] FAIL b2b_rsp%0d: got %h/%0b required %h/%0b", rsp, rsp_result,
                     rsp_carry, gr, gc);
          end
        end
        rsp++;
      end
      if (req_valid && req_ready) begin
        ref_op(req_a, req_b, req_select, req_mode, req_carry, er, ec);
        exp_r.push_back(er); exp_c.push_back(ec);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != WORDS + 2) begin
            errors++;
            $display("[TB] FAIL b2b_interval: got %0d required %0d", cyc - last_acc, WORDS + 2);
          end
        end
        last_acc = cyc; acc++; pending = 1'b1;
      end
      @(posedge clk);
      #1 if (acc == 4) req_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (rsp != 4) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d required 4", rsp);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    seen = 1'b0;
    issue(32'h0000FFFF, 32'h00000001, 4'b1001, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_result !== '0 || alu_carry_in !== 1'b0 ||
        alu_a !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got v=%0b rdy=%0b res=%h cin=%0b a=%h required 0/1/0/0/0",
               rsp_valid, req_ready, rsp_result, alu_carry_in, alu_a);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3 * WORDS + 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_no_rsp: got seen=%0b rdy=%0b required 0/1", seen, req_ready);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_wide_seq.md
# alu_wide_seq

Multi-word sequencer that sits directly upstream of the 16-bit combinational ALU and also consumes its output. It accepts one wide operation (WORDS × 16 bits) over a valid/ready request port and feeds the ALU one 16-bit slice per cycle, least-significant first. Each slice's ALU carry_out is chained into the next slice's carry_in. The assembled result and flags are returned over a valid/ready response port.

## Interface
- WORDS, default 2: number of 16-bit slices per operation; legal range 1–8.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  16*WORDS  operand A
- req_b  in  16*WORDS  operand B
- req_select  in  4  ALU function select, applied to every slice
- req_mode  in  1  0 = logic, 1 = arithmetic
- req_carry  in  1  carry/borrow into slice 0 (arithmetic mode only)
- alu_a, alu_b  out  16  current slice to ALU in_a / in_b
- alu_select  out  4  to ALU select
- alu_mode  out  1  to ALU mode
- alu_carry_in  out  1  to ALU carry_in
- alu_out  in  16  ALU result, combinational same cycle
- alu_carry_out  in  1  ALU carry_out, combinational same cycle
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream accepts response
- rsp_result  out  16*WORDS  assembled result
- rsp_carry  out  1  final carry/borrow (always 0 in logic mode)
- rsp_zero  out  1  1 when rsp_result is all zeros

## Operation
- FSM states: IDLE, RUN, DONE. Slice counter idx has width clog2(WORDS), minimum 1 bit.
- IDLE:
  - req_ready = 1.
  - On req_valid: capture a, b, select, mode; set carry_reg = req_carry & req_mode; set idx = 0; go to RUN.
- RUN:
  - alu_a = a[16*idx +: 16], alu_b = b[16*idx +: 16].
  - alu_select and alu_mode come from the captured registers; alu_carry_in = carry_reg.
  - Each clock: result[16*idx +: 16] <= alu_out.
  - carry_reg <= alu_carry_out when mode = 1, else 0. The ALU carry_out is ignored in logic mode.
  - When idx = WORDS−1, go to DONE; otherwise idx <= idx + 1.
- DONE:
  - rsp_valid = 1.
  - rsp_result, rsp_carry and rsp_zero are stable until the handshake.
  - On rsp_ready, go to IDLE.
- Outside RUN: alu_a = alu_b = 0, alu_carry_in = 0. alu_select and alu_mode hold their captured values (0 after reset).
- In subtract selects the ALU carry is a borrow; chaining is identical and no inversion is applied.
- The ALU compare output is not consumed.
- req_ready is 0 in RUN and DONE. req_valid in those states is ignored and not captured.
- rsp_zero = ~|result, registered with result.

## Timing
- Reset: asynchronous assert, synchronous deassert by the system.
  - State = IDLE, idx = 0, a/b/result = 0, select = 0, mode = 0, carry_reg = 0.
  - Outputs during and after reset: req_ready = 1, rsp_valid = 0, rsp_result = 0, rsp_carry = 0, rsp_zero = 1, all alu_* = 0.
- Reset mid-RUN or mid-DONE aborts the operation; no response is produced.
- Request accepted at edge T (req_valid & req_ready).
  - RUN occupies edges T+1 … T+WORDS.
  - rsp_valid is high after edge T+WORDS.
- Latency request-accept to rsp_valid is WORDS+1 cycles.
- Minimum issue interval is WORDS+2 cycles (one IDLE cycle between operations).
- rsp_valid held with rsp_ready = 0: all rsp_* remain unchanged indefinitely.
- WORDS = 1: a single RUN cycle, then DONE.

## Test plan
- WORDS = 2, mode 1, select 1001 (add), A = 0x0000FFFF, B = 0x00000001, req_carry = 0 -> rsp_result = 0x00010000, rsp_carry = 0, rsp_zero = 0. rsp_valid rises exactly 3 cycles after accept; alu_carry_in = 1 during slice 1.
- Add, A = 0xFFFFFFFF, B = 0x00000001 -> rsp_result = 0x00000000, rsp_carry = 1, rsp_zero = 1.
- Mode 0, select 0110 (xor), A = 0x12345678, B = 0xFFFF0000, req_carry = 1 -> rsp_result = 0xEDCB5678, rsp_carry = 0; alu_carry_in = 0 on both slices.
- Mode 1, select 0110 (A−B−cin), A = 0x00010000, B = 0x00000001, cin = 0 -> rsp_result = 0x0000FFFF, rsp_carry = 0. Slice-0 borrow of 1 is visible on alu_carry_in in slice 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles with a second req_valid pending -> rsp_* stable and req_ready = 0 throughout. The second request is accepted the cycle after the handshake.
- Drop rst_n during slice 1 of an add -> immediately rsp_valid = 0, req_ready = 1, rsp_result = 0. No response appears after rst_n is released.
